// File: rtl/ddr2_port_arbiter_if.sv
// rtl/ddr2_port_arbiter_if.sv - requester, controller and status signals around the DDR2 port arbiter
// The master modport is the arbiter; the slave modport is the requesters plus the memory controller.
interface ddr2_port_arbiter_if;
    logic        phy_init_done;
    logic        app_af_afull;
    logic        app_wdf_afull;

    logic        p0_req;
    logic        p0_wr;
    logic [30:0] p0_addr;
    logic        p0_ack;
    logic        p0_wdata_rden;
    logic [31:0] p0_wdata;

    logic        p1_req;
    logic        p1_wr;
    logic [30:0] p1_addr;
    logic        p1_ack;
    logic        p1_wdata_rden;
    logic [31:0] p1_wdata;

    logic        app_af_wren;
    logic [2:0]  app_af_cmd;
    logic [30:0] app_af_addr;
    logic        app_wdf_wren;
    logic [31:0] app_wdf_data;
    logic [3:0]  app_wdf_mask_data;

    modport master (
        input  phy_init_done, app_af_afull, app_wdf_afull,
        input  p0_req, p0_wr, p0_addr, p0_wdata,
        input  p1_req, p1_wr, p1_addr, p1_wdata,
        output p0_ack, p0_wdata_rden, p1_ack, p1_wdata_rden,
        output app_af_wren, app_af_cmd, app_af_addr,
        output app_wdf_wren, app_wdf_data, app_wdf_mask_data
    );

    modport slave (
        output phy_init_done, app_af_afull, app_wdf_afull,
        output p0_req, p0_wr, p0_addr, p0_wdata,
        output p1_req, p1_wr, p1_addr, p1_wdata,
        input  p0_ack, p0_wdata_rden, p1_ack, p1_wdata_rden,
        input  app_af_wren, app_af_cmd, app_af_addr,
        input  app_wdf_wren, app_wdf_data, app_wdf_mask_data
    );
endinterface

// File: rtl/ddr2_port_arbiter.sv
// rtl/ddr2_port_arbiter.sv - two-port round-robin burst arbiter in front of a DDR2 controller app interface
// Every output is a register loaded with the value computed for the state being entered.
module ddr2_port_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ddr2_port_arbiter_if.master     bus
);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, RD} state_t;

    state_t      state, state_nx;
    logic        last, last_nx;
    logic [3:0]  hold_cnt, hold_nx;
    logic        sel, sel_nx;
    logic [30:0] addr_l, addr_nx;

    logic [1:0]  ack_q, ack_nx;
    logic [1:0]  rden_q, rden_nx;
    logic        af_wren_q, af_wren_nx;
    logic [2:0]  af_cmd_q, af_cmd_nx;
    logic [30:0] af_addr_q, af_addr_nx;
    logic        wdf_wren_q, wdf_wren_nx;
    logic [31:0] wdf_data_q, wdf_data_nx;

    logic        elig0, elig1, win, win_wr;
    logic [30:0] win_addr;
    logic [31:0] sel_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last       <= 1'b1;
            hold_cnt   <= 4'd0;
            sel        <= 1'b0;
            addr_l     <= 31'd0;
            ack_q      <= 2'b00;
            rden_q     <= 2'b00;
            af_wren_q  <= 1'b0;
            af_cmd_q   <= 3'd0;
            af_addr_q  <= 31'd0;
            wdf_wren_q <= 1'b0;
            wdf_data_q <= 32'd0;
        end else begin
            state      <= state_nx;
            last       <= last_nx;
            hold_cnt   <= hold_nx;
            sel        <= sel_nx;
            addr_l     <= addr_nx;
            ack_q      <= ack_nx;
            rden_q     <= rden_nx;
            af_wren_q  <= af_wren_nx;
            af_cmd_q   <= af_cmd_nx;
            af_addr_q  <= af_addr_nx;
            wdf_wren_q <= wdf_wren_nx;
            wdf_data_q <= wdf_data_nx;
        end
    end

    always_comb begin
        elig0 = bus.p0_req && bus.phy_init_done && !bus.app_af_afull && !(bus.p0_wr && bus.app_wdf_afull);
        elig1 = bus.p1_req && bus.phy_init_done && !bus.app_af_afull && !(bus.p1_wr && bus.app_wdf_afull);
        // With both eligible the previous winner keeps the grant until its hold budget runs out.
        if (elig0 && elig1)
            win = (hold_cnt < HOLD_MAX) ? last : !last;
        else
            win = elig1;
        win_wr    = win ? bus.p1_wr   : bus.p0_wr;
        win_addr  = win ? bus.p1_addr : bus.p0_addr;
        sel_wdata = sel ? bus.p1_wdata : bus.p0_wdata;

        state_nx    = state;
        last_nx     = last;
        hold_nx     = hold_cnt;
        sel_nx      = sel;
        addr_nx     = addr_l;
        ack_nx      = 2'b00;
        rden_nx     = 2'b00;
        af_wren_nx  = 1'b0;
        af_cmd_nx   = 3'd0;
        af_addr_nx  = 31'd0;
        wdf_wren_nx = 1'b0;
        wdf_data_nx = wdf_data_q;

        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    sel_nx  = win;
                    addr_nx = win_addr;
                    if (win == last) begin
                        hold_nx = (hold_cnt < HOLD_MAX) ? hold_cnt + 4'd1 : hold_cnt;
                    end else begin
                        hold_nx = 4'd1;
                        last_nx = win;
                    end
                    if (win_wr) begin
                        state_nx     = WR0;
                        rden_nx[win] = 1'b1;
                    end else begin
                        state_nx    = RD;
                        af_wren_nx  = 1'b1;
                        af_cmd_nx   = 3'b001;
                        af_addr_nx  = win_addr;
                        ack_nx[win] = 1'b1;
                    end
                end else begin
                    hold_nx = 4'd0;
                end
            end
            WR0: begin
                state_nx     = WR1;
                rden_nx[sel] = 1'b1;
            end
            WR1: begin
                // Word0 appears on the port FIFO output the cycle after the WR0 strobe.
                state_nx    = WR2;
                wdf_data_nx = sel_wdata;
                wdf_wren_nx = 1'b1;
                af_wren_nx  = 1'b1;
                af_cmd_nx   = 3'b000;
                af_addr_nx  = addr_l;
                ack_nx[sel] = 1'b1;
            end
            WR2: begin
                state_nx    = IDLE;
                wdf_data_nx = sel_wdata;
                wdf_wren_nx = 1'b1;
            end
            RD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.p0_ack            = ack_q[0];
    assign bus.p1_ack            = ack_q[1];
    assign bus.p0_wdata_rden     = rden_q[0];
    assign bus.p1_wdata_rden     = rden_q[1];
    assign bus.app_af_wren       = af_wren_q;
    assign bus.app_af_cmd        = af_cmd_q;
    assign bus.app_af_addr       = af_addr_q;
    assign bus.app_wdf_wren      = wdf_wren_q;
    assign bus.app_wdf_data      = wdf_data_q;
    assign bus.app_wdf_mask_data = 4'b0000;
endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// tb/tb_ddr2_port_arbiter.sv - scoreboard bench for ddr2_port_arbiter
module tb_ddr2_port_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ddr2_port_arbiter_if bus ();

    ddr2_port_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed { logic wr; logic [30:0] addr; } burst_t;
    typedef struct packed { logic port; logic [2:0] cmd; logic [30:0] addr; } cmd_t;

    burst_t      rq0[$], rq1[$];
    logic [31:0] wq0[$], wq1[$];
    cmd_t        exp_cmd[$];
    logic [31:0] exp_data[$];
    int          af_cyc[$];

    int total = 0, bad = 0;
    int cyc = 0, af_count = 0, rden_count = 0;
    int wrun = 0, r0run = 0, r1run = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic req_burst(input bit port, input bit wr, input logic [30:0] addr,
                             input logic [31:0] d0, input logic [31:0] d1);
        burst_t b;
        b.wr = wr;
        b.addr = addr;
        if (port == 1'b0) begin
            rq0.push_back(b);
            if (wr) begin wq0.push_back(d0); wq0.push_back(d1); end
        end else begin
            rq1.push_back(b);
            if (wr) begin wq1.push_back(d0); wq1.push_back(d1); end
        end
    endtask

    task automatic expect_burst(input bit port, input bit wr, input logic [30:0] addr,
                                input logic [31:0] d0, input logic [31:0] d1);
        cmd_t c;
        c.port = port;
        c.cmd  = wr ? 3'b000 : 3'b001;
        c.addr = addr;
        exp_cmd.push_back(c);
        if (wr) begin exp_data.push_back(d0); exp_data.push_back(d1); end
    endtask

    task automatic wait_af(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.app_af_wren && n < 50);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((rq0.size() + rq1.size() + exp_cmd.size() + exp_data.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < 300, 1);
        repeat (2) @(negedge clk);
    endtask

    // Requester FIFOs: req/addr advance on the ack edge, data is valid the cycle after rden.
    always @(posedge clk) begin
        if (!reset_n) begin
            rq0.delete(); wq0.delete();
            bus.p0_req <= 1'b0; bus.p0_wr <= 1'b0; bus.p0_addr <= '0; bus.p0_wdata <= '0;
        end else begin
            if (bus.p0_ack && rq0.size() > 0) rq0.delete(0);
            if (bus.p0_wdata_rden && wq0.size() > 0) begin bus.p0_wdata <= wq0[0]; wq0.delete(0); end
            if (rq0.size() > 0) begin
                bus.p0_req <= 1'b1; bus.p0_wr <= rq0[0].wr; bus.p0_addr <= rq0[0].addr;
            end else bus.p0_req <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            rq1.delete(); wq1.delete();
            bus.p1_req <= 1'b0; bus.p1_wr <= 1'b0; bus.p1_addr <= '0; bus.p1_wdata <= '0;
        end else begin
            if (bus.p1_ack && rq1.size() > 0) rq1.delete(0);
            if (bus.p1_wdata_rden && wq1.size() > 0) begin bus.p1_wdata <= wq1[0]; wq1.delete(0); end
            if (rq1.size() > 0) begin
                bus.p1_req <= 1'b1; bus.p1_wr <= rq1[0].wr; bus.p1_addr <= rq1[0].addr;
            end else bus.p1_req <= 1'b0;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        cmd_t e;
        if (reset_n) begin
            if (bus.app_af_wren || bus.p0_ack || bus.p1_ack) begin
                af_count++;
                af_cyc.push_back(cyc);
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected", 1, 0);
                end else begin
                    e = exp_cmd.pop_front();
                    check("af_wren", bus.app_af_wren, 1);
                    check("af_cmd", bus.app_af_cmd, e.cmd);
                    check("af_addr", bus.app_af_addr, e.addr);
                    check("ack", {bus.p1_ack, bus.p0_ack}, e.port ? 2'b10 : 2'b01);
                end
            end
            if (bus.app_wdf_wren) begin
                check("wdf_mask", bus.app_wdf_mask_data, 0);
                if (exp_data.size() == 0) check("wdf_unexpected", 1, 0);
                else check("wdf_data", bus.app_wdf_data, exp_data.pop_front());
            end
            if (bus.p0_wdata_rden || bus.p1_wdata_rden) rden_count++;
            if (bus.app_wdf_wren) wrun++;
            else if (wrun != 0) begin check("wdf_run", wrun, 2); wrun = 0; end
            if (bus.p0_wdata_rden) r0run++;
            else if (r0run != 0) begin check("p0_rden_run", r0run, 2); r0run = 0; end
            if (bus.p1_wdata_rden) r1run++;
            else if (r1run != 0) begin check("p1_rden_run", r1run, 2); r1run = 0; end
        end
    end

    initial begin
        int n, snap, i0, i1;
        bus.phy_init_done = 1'b1;
        bus.app_af_afull  = 1'b0;
        bus.app_wdf_afull = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {bus.p0_ack, bus.p1_ack, bus.p0_wdata_rden, bus.p1_wdata_rden,
                          bus.app_af_wren, bus.app_wdf_wren, bus.app_af_cmd, bus.app_wdf_mask_data}, 0);
        check("rst_addr", bus.app_af_addr, 0);
        check("rst_data", bus.app_wdf_data, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single write on p1
        req_burst(1, 1, 31'h200, 32'hAAAA0001, 32'hBBBB0002);
        expect_burst(1, 1, 31'h200, 32'hAAAA0001, 32'hBBBB0002);
        wait_af(n);
        check("wr_latency", n, 4);
        check("wdf_with_af", bus.app_wdf_wren, 1);
        wait_idle("wr_single_done");

        // Single read on p0
        req_burst(0, 0, 31'h100, 0, 0);
        expect_burst(0, 0, 31'h100, 0, 0);
        wait_af(n);
        check("rd_latency", n, 2);
        wait_idle("rd_single_done");

        // Fairness: p0 won last, so grants go p0x4, p1x4, ...
        af_cyc.delete();
        for (int i = 0; i < 12; i++) req_burst(0, 0, 31'h1000 + 31'(4 * i), 0, 0);
        for (int i = 0; i < 8; i++)  req_burst(1, 0, 31'h2000 + 31'(4 * i), 0, 0);
        i0 = 0; i1 = 0;
        for (int g = 0; g < 20; g++) begin
            if (((g / 4) % 2) == 0) begin expect_burst(0, 0, 31'h1000 + 31'(4 * i0), 0, 0); i0++; end
            else                    begin expect_burst(1, 0, 31'h2000 + 31'(4 * i1), 0, 0); i1++; end
        end
        wait_idle("fair_done");
        check("fair_count", af_cyc.size(), 20);
        if (af_cyc.size() == 20) check("rd_throughput", af_cyc[19] - af_cyc[0], 38);

        // Only p0 requesting keeps winning past MAX_HOLD
        for (int i = 0; i < 6; i++) begin
            req_burst(0, 0, 31'h3000 + 31'(4 * i), 0, 0);
            expect_burst(0, 0, 31'h3000 + 31'(4 * i), 0, 0);
        end
        wait_idle("p0_only_done");

        // Write-data FIFO almost full: p1 reads pass, p0 write waits
        bus.app_wdf_afull = 1'b1;
        req_burst(0, 1, 31'h300, 32'h11110001, 32'h22220002);
        for (int i = 0; i < 3; i++) begin
            req_burst(1, 0, 31'h400 + 31'(4 * i), 0, 0);
            expect_burst(1, 0, 31'h400 + 31'(4 * i), 0, 0);
        end
        n = 0;
        while (exp_cmd.size() != 0 && n < 100) begin @(negedge clk); n++; end
        repeat (6) @(negedge clk);
        check("wdf_afull_reads", exp_cmd.size(), 0);
        check("p0_write_waiting", rq0.size(), 1);
        expect_burst(0, 1, 31'h300, 32'h11110001, 32'h22220002);
        bus.app_wdf_afull = 1'b0;
        wait_idle("wdf_afull_done");

        // Address FIFO almost full: nothing issued
        bus.app_af_afull = 1'b1;
        snap = af_count;
        req_burst(0, 0, 31'h500, 0, 0);
        repeat (20) @(negedge clk);
        check("af_afull_block", af_count - snap, 0);
        expect_burst(0, 0, 31'h500, 0, 0);
        bus.app_af_afull = 1'b0;
        wait_idle("af_afull_done");

        // PHY not initialised: no activity at all
        bus.phy_init_done = 1'b0;
        snap = af_count + rden_count;
        req_burst(1, 1, 31'h580, 32'hC0DE0001, 32'hC0DE0002);
        repeat (20) @(negedge clk);
        check("phy_block", af_count + rden_count - snap, 0);
        expect_burst(1, 1, 31'h580, 32'hC0DE0001, 32'hC0DE0002);
        bus.phy_init_done = 1'b1;
        wait_idle("phy_done");

        // Reset in WR1 abandons the burst
        req_burst(0, 1, 31'h600, 32'hDEAD0001, 32'hDEAD0002);
        n = 0;
        while (!bus.p0_wdata_rden && n < 50) begin @(negedge clk); n++; end
        check("wr0_seen", bus.p0_wdata_rden, 1);
        @(negedge clk);
        check("wr1_rden", bus.p0_wdata_rden, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_ctl", {bus.p0_ack, bus.p1_ack, bus.p0_wdata_rden, bus.p1_wdata_rden,
                                bus.app_af_wren, bus.app_wdf_wren, bus.app_af_cmd}, 0);
        check("async_rst_addr", bus.app_af_addr, 0);
        check("async_rst_data", bus.app_wdf_data, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        req_burst(0, 0, 31'h700, 0, 0);
        expect_burst(0, 0, 31'h700, 0, 0);
        wait_af(n);
        check("post_rst_latency", n, 2);
        wait_idle("post_rst_done");

        check("exp_cmd_empty", exp_cmd.size(), 0);
        check("exp_data_empty", exp_data.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
